// File: rtl/mem_ctrl_pkg.sv
// Shared types and constants for the byte-serial RAM controller.
package mem_ctrl_pkg;

  localparam int RAM_ADDR_W_DEF = 17;

  localparam logic [1:0] MEM_BYTE = 2'd0;
  localparam logic [1:0] MEM_HALF = 2'd1;
  localparam logic [1:0] MEM_WORD = 2'd2;

  typedef enum logic [1:0] {
    MC_IDLE     = 2'd0,
    MC_BUSY_IF  = 2'd1,
    MC_BUSY_MEM = 2'd2
  } mc_state_t;

  // Size code 3 is deliberately folded into the word case.
  function automatic logic [2:0] beat_count(input logic [1:0] size);
    case (size)
      MEM_BYTE: beat_count = 3'd1;
      MEM_HALF: beat_count = 3'd2;
      default:  beat_count = 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/mem_ctrl_arb.sv
// Grant decision between IF and MEM, taken only while the controller is idle.
// MEM_CTRL_RR_EN: round-robin on ties; otherwise MEM has fixed priority.
module mem_ctrl_arb (
`ifdef MEM_CTRL_RR_EN
  input  logic clk,
  input  logic rst,
`endif
  input  logic idle_i,
  input  logic if_req_i,
  input  logic mem_req_i,
  output logic gnt_if_o,
  output logic gnt_mem_o
);

  logic mem_pri;

`ifdef MEM_CTRL_RR_EN
  // Set when MEM was served last; reset to IF so MEM takes the first tie.
  logic last_mem_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_mem_q <= 1'b0;
    end else if (gnt_mem_o) begin
      last_mem_q <= 1'b1;
    end else if (gnt_if_o) begin
      last_mem_q <= 1'b0;
    end
  end

  assign mem_pri = ~last_mem_q;
`else
  assign mem_pri = 1'b1;
`endif

  always_comb begin
    gnt_mem_o = idle_i & mem_req_i & (~if_req_i | mem_pri);
    gnt_if_o  = idle_i & if_req_i & (~mem_req_i | ~mem_pri);
  end

endmodule

// File: rtl/mem_ctrl.sv
// Sequences IF fetches and MEM loads/stores onto one byte-wide RAM, little-endian beats.
// MEM_CTRL_RR_EN (optional) switches the arbiter to round-robin on simultaneous requests.
module mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int RAM_ADDR_W = RAM_ADDR_W_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  if_req,
  input  logic [31:0]           if_addr,
  input  logic                  if_flush,
  output logic [31:0]           if_data,
  output logic                  if_done,
  input  logic                  mem_req,
  input  logic                  mem_wr,
  input  logic [1:0]            mem_size,
  input  logic [31:0]           mem_addr,
  input  logic [31:0]           mem_wdata,
  output logic [31:0]           mem_rdata,
  output logic                  mem_done,
  output logic                  stall_if,
  output logic                  stall_mem,
  output logic [RAM_ADDR_W-1:0] ram_a,
  output logic [7:0]            ram_dout,
  output logic                  ram_wr,
  input  logic [7:0]            ram_din
);

  mc_state_t             state_q;
  logic [2:0]            cnt_q;
  logic [2:0]            nbeats_q;
  logic [31:0]           addr_q;
  logic [31:0]           wdata_q;
  logic [31:0]           rd_q;
  logic                  wr_q;
  logic                  if_done_q;
  logic                  mem_done_q;
  logic                  ram_wr_q;
  logic [RAM_ADDR_W-1:0] ram_a_q;
  logic [7:0]            ram_dout_q;

  logic [2:0]            cnt_d;
  logic [31:0]           addr_d;
  logic [1:0]            byte_idx;
  logic                  last_beat;
  logic                  gnt_if;
  logic                  gnt_mem;

  // cnt_q is the beat on ram_a; ram_din carries the byte of beat cnt_q-1.
  always_comb begin
    cnt_d     = cnt_q + 3'd1;
    addr_d    = addr_q + {29'd0, cnt_d};
    byte_idx  = cnt_q[1:0] - 2'd1;
    last_beat = wr_q ? (cnt_d == nbeats_q) : (cnt_q == nbeats_q);
  end

  mem_ctrl_arb u_arb (
`ifdef MEM_CTRL_RR_EN
    .clk       (clk),
    .rst       (rst),
`endif
    .idle_i    (state_q == MC_IDLE),
    .if_req_i  (if_req & ~if_flush),
    .mem_req_i (mem_req),
    .gnt_if_o  (gnt_if),
    .gnt_mem_o (gnt_mem)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= MC_IDLE;
      cnt_q      <= 3'd0;
      nbeats_q   <= 3'd0;
      addr_q     <= 32'd0;
      wdata_q    <= 32'd0;
      rd_q       <= 32'd0;
      wr_q       <= 1'b0;
      if_done_q  <= 1'b0;
      mem_done_q <= 1'b0;
      ram_wr_q   <= 1'b0;
      ram_a_q    <= '0;
      ram_dout_q <= 8'd0;
    end else begin
      if_done_q  <= 1'b0;
      mem_done_q <= 1'b0;
      case (state_q)
        MC_IDLE: begin
          if (gnt_mem) begin
            state_q    <= MC_BUSY_MEM;
            cnt_q      <= 3'd0;
            nbeats_q   <= beat_count(mem_size);
            addr_q     <= mem_addr;
            wr_q       <= mem_wr;
            wdata_q    <= mem_wr ? mem_wdata : 32'd0;
            rd_q       <= 32'd0;
            ram_a_q    <= mem_addr[RAM_ADDR_W-1:0];
            ram_wr_q   <= mem_wr;
            ram_dout_q <= mem_wr ? mem_wdata[7:0] : 8'd0;
          end else if (gnt_if) begin
            state_q    <= MC_BUSY_IF;
            cnt_q      <= 3'd0;
            nbeats_q   <= 3'd4;
            addr_q     <= if_addr;
            wr_q       <= 1'b0;
            wdata_q    <= 32'd0;
            rd_q       <= 32'd0;
            ram_a_q    <= if_addr[RAM_ADDR_W-1:0];
            ram_wr_q   <= 1'b0;
            ram_dout_q <= 8'd0;
          end
        end
        MC_BUSY_IF, MC_BUSY_MEM: begin
          if (state_q == MC_BUSY_IF && if_flush) begin
            state_q <= MC_IDLE;
            cnt_q   <= 3'd0;
          end else begin
            cnt_q <= cnt_d;
            if (!wr_q && cnt_q != 3'd0) begin
              rd_q[{byte_idx, 3'b000} +: 8] <= ram_din;
            end
            if (cnt_d < nbeats_q) begin
              ram_a_q    <= addr_d[RAM_ADDR_W-1:0];
              ram_dout_q <= wdata_q[{cnt_d[1:0], 3'b000} +: 8];
            end else begin
              ram_wr_q   <= 1'b0;
              ram_dout_q <= 8'd0;
            end
            if (last_beat) begin
              state_q    <= MC_IDLE;
              cnt_q      <= 3'd0;
              if_done_q  <= (state_q == MC_BUSY_IF);
              mem_done_q <= (state_q == MC_BUSY_MEM);
            end
          end
        end
        default: state_q <= MC_IDLE;
      endcase
    end
  end

  // Only the low RAM_ADDR_W address bits reach the RAM.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{if_addr[31:RAM_ADDR_W], mem_addr[31:RAM_ADDR_W],
                              addr_d[31:RAM_ADDR_W]};

  assign if_done   = if_done_q;
  assign mem_done  = mem_done_q;
  assign if_data   = if_done_q  ? rd_q : 32'd0;
  assign mem_rdata = mem_done_q ? rd_q : 32'd0;
  assign stall_if  = rst & if_req  & ~if_done_q;
  assign stall_mem = rst & mem_req & ~mem_done_q;
  assign ram_a     = ram_a_q;
  assign ram_dout  = ram_dout_q;
  assign ram_wr    = ram_wr_q;

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed bench for mem_ctrl with a behavioural 1-cycle-latency byte RAM.
module tb_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        if_req = 1'b0, if_flush = 1'b0, if_done;
  logic [31:0] if_addr = 32'd0, if_data;
  logic        mem_req = 1'b0, mem_wr = 1'b0, mem_done;
  logic [1:0]  mem_size = 2'd0;
  logic [31:0] mem_addr = 32'd0, mem_wdata = 32'd0, mem_rdata;
  logic        stall_if, stall_mem, ram_wr;
  logic [16:0] ram_a;
  logic [7:0]  ram_dout, ram_din;

  int nvec = 0;
  int nerr = 0;

  logic [7:0]  ram [0:131071];
  logic [24:0] wlog [$];

  always #5 clk = ~clk;

  mem_ctrl dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush), .if_data(if_data), .if_done(if_done),
    .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_done(mem_done),
    .stall_if(stall_if), .stall_mem(stall_mem),
    .ram_a(ram_a), .ram_dout(ram_dout), .ram_wr(ram_wr), .ram_din(ram_din)
  );

  always @(posedge clk) begin
    ram_din <= ram[ram_a];
    if (ram_wr === 1'b1) begin
      ram[ram_a] = ram_dout;
      wlog.push_back({ram_a, ram_dout});
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_ctl"}, {27'd0, if_done, mem_done, ram_wr, stall_if, stall_mem}, 32'd0);
    chk({tag, "_ram_a"}, {15'd0, ram_a}, 32'd0);
    chk({tag, "_ram_dout"}, {24'd0, ram_dout}, 32'd0);
    chk({tag, "_rdata"}, if_data | mem_rdata, 32'd0);
  endtask

  task automatic run_fetch(input logic [31:0] a, input logic [31:0] exp, input string tag);
    int lat;
    bit seen;
    logic [31:0] ea;
    lat = 0;
    seen = 1'b0;
    if_addr = a;
    if_req = 1'b1;
    for (int i = 1; i <= 20 && !seen; i++) begin
      @(negedge clk);
      if (i == 1) chk({tag, "_stall"}, {31'd0, stall_if}, 32'd1);
      if (i <= 4) begin
        ea = a + i - 1;
        chk({tag, "_beat_a"}, {15'd0, ram_a}, {15'd0, ea[16:0]});
      end
      if (if_done) begin
        seen = 1'b1;
        lat = i;
        chk({tag, "_data"}, if_data, exp);
        if_req = 1'b0;
      end
    end
    chk({tag, "_lat"}, lat, 32'd6);
  endtask

  task automatic run_mem(input logic wr, input logic [1:0] sz, input logic [31:0] a,
                         input logic [31:0] wd, input logic [31:0] exp, input int exp_lat,
                         input string tag);
    int lat;
    bit seen;
    lat = 0;
    seen = 1'b0;
    mem_wr = wr;
    mem_size = sz;
    mem_addr = a;
    mem_wdata = wd;
    mem_req = 1'b1;
    for (int i = 1; i <= 20 && !seen; i++) begin
      @(negedge clk);
      if (i == 1) chk({tag, "_stall"}, {31'd0, stall_mem}, 32'd1);
      if (mem_done) begin
        seen = 1'b1;
        lat = i;
        if (!wr) chk({tag, "_data"}, mem_rdata, exp);
        mem_req = 1'b0;
      end
    end
    chk({tag, "_lat"}, lat, exp_lat);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not reach the summary");
    $fatal(1, "timeout");
  end

  initial begin : stim
    int dones;
    int k;
    logic [7:0] ord [4];
    logic [7:0] exp_ord [4];

    for (int i = 0; i < 131072; i++) ram[i] = 8'h00;
    ram[17'h00100] = 8'h13;
    {ram[17'h00203], ram[17'h00202], ram[17'h00201], ram[17'h00200]} = 32'hDEADBEEF;
    {ram[17'h00403], ram[17'h00402], ram[17'h00401], ram[17'h00400]} = 32'h0BADF00D;
    {ram[17'h00503], ram[17'h00502], ram[17'h00501], ram[17'h00500]} = 32'hCAFE1234;
    ram[17'h02003] = 8'h5A;
    ram[17'h03003] = 8'h80;
    ram[17'h1FFFF] = 8'h34;
    ram[17'h00000] = 8'h12;
    ram[17'h06000] = 8'hA5;
    ram[17'h06001] = 8'hA5;

    // Reset state, with both requests held to show stalls are masked.
    if_req = 1'b1;
    mem_req = 1'b1;
    repeat (2) @(negedge clk);
    chk_zero("reset");
    if_req = 1'b0;
    mem_req = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    chk_zero("idle");

    // Fetch of 0x100.
    run_fetch(32'h0000_0100, 32'h0000_0013, "fetch100");
    @(negedge clk);
    chk("if_done_pulse", {31'd0, if_done}, 32'd0);

    // Half store at odd address: two beats only.
    wlog.delete();
    run_mem(1'b1, 2'd1, 32'h0000_2001, 32'hAABB_CCDD, 32'd0, 3, "st_half");
    chk("st_half_nbeats", wlog.size(), 32'd2);
    chk("st_half_b0", {7'd0, wlog[0]}, {7'd0, 17'h02001, 8'hDD});
    chk("st_half_b1", {7'd0, wlog[1]}, {7'd0, 17'h02002, 8'hCC});
    chk("st_half_untouched", {24'd0, ram[17'h02003]}, 32'h0000_005A);

    // Loads: byte, half wrapping across 2^32, size 3 as word with if_flush asserted.
    run_mem(1'b0, 2'd0, 32'h0000_3003, 32'd0, 32'h0000_0080, 3, "ld_byte");
    run_mem(1'b0, 2'd1, 32'hFFFF_FFFF, 32'd0, 32'h0000_1234, 4, "ld_half_wrap");
    if_flush = 1'b1;
    run_mem(1'b0, 2'd3, 32'h0000_0200, 32'd0, 32'hDEAD_BEEF, 6, "ld_size3_flush");
    if_flush = 1'b0;

    // Flush on beat 2 of a fetch.
    wlog.delete();
    if_addr = 32'h0000_0100;
    if_req = 1'b1;
    repeat (3) @(negedge clk);
    chk("flush_beat2_a", {15'd0, ram_a}, 32'h0000_0102);
    if_flush = 1'b1;
    if_req = 1'b0;
    @(negedge clk);
    if_flush = 1'b0;
    dones = 0;
    repeat (8) begin
      @(negedge clk);
      if (if_done) dones++;
    end
    chk("flush_no_done", dones, 32'd0);
    chk("flush_no_write", wlog.size(), 32'd0);

    // Flush in IDLE masks a same-cycle request.
    if_req = 1'b1;
    if_flush = 1'b1;
    @(negedge clk);
    if_req = 1'b0;
    if_flush = 1'b0;
    dones = 0;
    repeat (8) begin
      @(negedge clk);
      if (if_done) dones++;
    end
    chk("idle_flush_ignored", dones, 32'd0);
    run_fetch(32'h0000_0200, 32'hDEAD_BEEF, "fetch200");

    // Async reset in the middle of a word store.
    mem_wr = 1'b1;
    mem_size = 2'd2;
    mem_addr = 32'h0000_6000;
    mem_wdata = 32'h1122_3344;
    mem_req = 1'b1;
    @(negedge clk);
    chk("rstmid_wr", {31'd0, ram_wr}, 32'd1);
    @(negedge clk);
    chk("rstmid_dout", {24'd0, ram_dout}, 32'h0000_0033);
    #1 rst = 1'b0;
    #1 chk_zero("rstmid");
    mem_req = 1'b0;
    mem_wr = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk_zero("post_rst");
    chk("rstmid_b0", {24'd0, ram[17'h06000]}, 32'h0000_0044);
    chk("rstmid_b1", {24'd0, ram[17'h06001]}, 32'h0000_00A5);

    // Single tie: MEM served first, then IF.
    k = 0;
    if_addr = 32'h0000_0400;
    mem_wr = 1'b0;
    mem_size = 2'd2;
    mem_addr = 32'h0000_0500;
    if_req = 1'b1;
    mem_req = 1'b1;
    for (int i = 0; i < 40 && k < 2; i++) begin
      @(negedge clk);
      if (if_done && mem_done) chk("tie1_both_done", 32'd1, 32'd0);
      if (mem_done) begin
        ord[k] = "M";
        k++;
        chk("tie1_mem_data", mem_rdata, 32'hCAFE_1234);
        mem_req = 1'b0;
      end else if (if_done) begin
        ord[k] = "I";
        k++;
        chk("tie1_if_data", if_data, 32'h0BAD_F00D);
        if_req = 1'b0;
      end
    end
    chk("tie1_count", k, 32'd2);
    chk("tie1_order", {16'd0, ord[0], ord[1]}, {16'd0, 8'h4D, 8'h49});
    if_req = 1'b0;
    mem_req = 1'b0;
    @(negedge clk);

    // Four back-to-back tie rounds with both requests held.
`ifdef MEM_CTRL_RR_EN
    exp_ord = '{8'h4D, 8'h49, 8'h4D, 8'h49};
`else
    exp_ord = '{8'h4D, 8'h4D, 8'h4D, 8'h4D};
`endif
    k = 0;
    if_req = 1'b1;
    mem_req = 1'b1;
    for (int i = 0; i < 80 && k < 4; i++) begin
      @(negedge clk);
      if (mem_done) begin
        ord[k] = "M";
        k++;
        chk("tie4_mem_data", mem_rdata, 32'hCAFE_1234);
      end else if (if_done) begin
        ord[k] = "I";
        k++;
        chk("tie4_if_data", if_data, 32'h0BAD_F00D);
      end
      if (k == 4) begin
        if_req = 1'b0;
        mem_req = 1'b0;
      end
    end
    if_req = 1'b0;
    mem_req = 1'b0;
    chk("tie4_count", k, 32'd4);
    chk("tie4_order", {ord[0], ord[1], ord[2], ord[3]},
        {exp_ord[0], exp_ord[1], exp_ord[2], exp_ord[3]});
    repeat (3) @(negedge clk);
    chk("end_idle_wr", {31'd0, ram_wr}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
